// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ext
//  Purpose  : Parametrised oversampling UART receiver with parity, framing
//             and optional line-break detection (UART_RX_BREAK_DET_EN).
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_ext #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] HALF_M1    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = (STOP_BITS == 2);
  localparam logic          HAS_PARITY = (PARITY_MODE != 0);
  localparam logic          ODD_PARITY = (PARITY_MODE == 2);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
`ifdef UART_RX_BREAK_DET_EN
  localparam logic [2:0] S_BRK_WAIT = 3'd5;
`endif

  logic                 rx_meta;
  logic                 rxs;
  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 frm_acc;

  logic at_half;
  logic at_full;
  logic last_bit;
  logic last_stop;
  logic brk_frame;

  logic cnt_clear;
  logic cnt_step;
  logic frame_start;
  logic shift_en;
  logic par_en;
  logic stop_en;
  logic frame_end;

  assign at_half   = (sample_cnt == HALF_M1);
  assign at_full   = (sample_cnt == FULL_M1);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_stop = (stop_cnt == STOP_LAST);

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!rxs) state_next = S_START;
      S_START:  if (s_tick && at_half) state_next = rxs ? S_IDLE : S_DATA;
      S_DATA:   if (s_tick && at_full && last_bit)
                  state_next = HAS_PARITY ? S_PARITY : S_STOP;
      S_PARITY: if (s_tick && at_full) state_next = S_STOP;
      S_STOP:   if (s_tick && at_full && last_stop) begin
`ifdef UART_RX_BREAK_DET_EN
                  state_next = brk_frame ? S_BRK_WAIT : S_IDLE;
`else
                  state_next = S_IDLE;
`endif
                end
`ifdef UART_RX_BREAK_DET_EN
      S_BRK_WAIT: if (rxs) state_next = S_IDLE;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clear   = 1'b0;
    cnt_step    = 1'b0;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    frame_end   = 1'b0;
    case (state)
      S_IDLE: cnt_clear = 1'b1;
      S_START: begin
        if (s_tick) begin
          if (at_half) begin
            cnt_clear   = 1'b1;
            frame_start = !rxs;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (s_tick) begin
          if (at_full) begin
            cnt_clear = 1'b1;
            shift_en  = (state == S_DATA);
            par_en    = (state == S_PARITY);
            stop_en   = (state == S_STOP);
            frame_end = (state == S_STOP) && last_stop;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      frm_acc      <= 1'b0;
      rx_data      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= frame_end;
      if (cnt_clear)     sample_cnt <= '0;
      else if (cnt_step) sample_cnt <= sample_cnt + 1'b1;
      if (frame_start) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        par_acc  <= 1'b0;
        frm_acc  <= 1'b0;
      end
      // Right shift: first bit on the line ends up in the LSB
      if (shift_en) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en) par_acc <= (^shreg) ^ rxs ^ ODD_PARITY;
      if (stop_en) begin
        stop_cnt <= stop_cnt + 1'b1;
        if (!rxs) frm_acc <= 1'b1;
      end
      if (frame_end) begin
        rx_data    <= shreg;
        parity_err <= par_acc;
        frame_err  <= frm_acc | ~rxs;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic par_bit;
  logic stop_one;

  // Break: every bit of the frame, stop bits included, sampled low
  assign brk_frame = (shreg == '0) && !par_bit && !stop_one && !rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit   <= 1'b0;
      stop_one  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= frame_end && brk_frame;
      if (frame_start) begin
        par_bit  <= 1'b0;
        stop_one <= 1'b0;
      end
      if (par_en) par_bit <= rxs;
      if (stop_en && rxs) stop_one <= 1'b1;
    end
  end
`else
  assign brk_frame = 1'b0;
  assign break_det = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// Randomised bench for uart_rx_ext: an 8N1/x16 instance and a 7E2/x8 instance
// driven by a shared s_tick, checked against a frame-level reference model.
module tb_uart_rx_ext;

  localparam int TP = 3;

`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  int   div = 0;

  logic [7:0] data0;
  logic       done0, perr0, ferr0, brk_det0;
  logic [6:0] data1;
  logic       done1, perr1, ferr1, brk_det1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div    <= (div == TP - 1) ? 0 : div + 1;
    s_tick <= (div == TP - 1);
  end

  uart_rx_ext u_dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx0),
    .rx_data(data0), .rx_done_tick(done0), .parity_err(perr0),
    .frame_err(ferr0), .break_det(brk_det0)
  );

  uart_rx_ext #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_MODE(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx1),
    .rx_data(data1), .rx_done_tick(done1), .parity_err(perr1),
    .frame_err(ferr1), .break_det(brk_det1)
  );

  // Entry layout: {tick_before_done, break_det, frame_err, parity_err, data[8:0]}
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  int   brk0 = 0;
  int   brk1 = 0;
  logic tick_q = 1'b0;

  always @(posedge clk) tick_q <= s_tick;

  always @(negedge clk) begin
    if (done0) q0.push_back({tick_q, brk_det0, ferr0, perr0, 1'b0, data0});
    if (done1) q1.push_back({tick_q, brk_det1, ferr1, perr1, 2'b00, data1});
    if (brk_det0) brk0 <= brk0 + 1;
    if (brk_det1) brk1 <= brk1 + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic get_cfg(input int d, output int nb, output int os, output int pm, output int ns);
    if (d == 0) begin nb = 8; os = 16; pm = 0; ns = 1; end
    else        begin nb = 7; os = 8;  pm = 1; ns = 2; end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input int d, input logic b);
    if (d == 0) rx0 = b;
    else        rx1 = b;
  endtask

  function automatic int good_pbit(input int data, input int pm);
    return ($countones(data) % 2) ^ ((pm == 2) ? 1 : 0);
  endfunction

  // A trailing low stop bit is cut short so the receiver does not see the
  // remainder of it as a fresh start bit.
  task automatic send_frame(input int d, input int data, input int pbit, input int stops);
    int nb, os, pm, ns;
    int bits[$];
    get_cfg(d, nb, os, pm, ns);
    bits.push_back(0);
    for (int i = 0; i < nb; i++) bits.push_back((data >> i) & 1);
    if (pm != 0) bits.push_back(pbit & 1);
    for (int s = 0; s < ns; s++) bits.push_back((stops >> s) & 1);
    for (int i = 0; i < bits.size(); i++) begin
      drive(d, bits[i][0]);
      wait_ticks((i == bits.size() - 1 && bits[i] == 0) ? os / 2 + 2 : os);
    end
    drive(d, 1'b1);
    wait_ticks(os / 2 + 2 + $urandom_range(0, os));
  endtask

  task automatic expect_entry(input string tag, input int d, input int data,
                              input bit perr, input bit ferr, input bit brk);
    logic [12:0] e;
    int sz;
    sz = (d == 0) ? q0.size() : q1.size();
    check({tag, "_count"}, sz, 1);
    if (sz == 0) return;
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check({tag, "_data"}, e[8:0], data);
    check({tag, "_perr"}, e[9], perr);
    check({tag, "_ferr"}, e[10], ferr);
    check({tag, "_brk"}, e[11], brk);
    check({tag, "_align"}, e[12], 1);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic frame_check(input string tag, input int d, input int data,
                             input int pbit, input int stops);
    int nb, os, pm, ns, full;
    bit perr, ferr, brk;
    get_cfg(d, nb, os, pm, ns);
    data = data & ((1 << nb) - 1);
    full = (1 << ns) - 1;
    perr = (pm != 0) && ((($countones(data) + pbit) % 2 == 1) != (pm == 2));
    ferr = ((stops & full) != full);
    brk  = BRK_EN && (data == 0) && (pm == 0 || pbit == 0) && ((stops & full) == 0);
    send_frame(d, data, pbit, stops);
    expect_entry(tag, d, data, perr, ferr, brk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data0"}, data0, 0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_perr0"}, perr0, 0);
    check({tag, "_ferr0"}, ferr0, 0);
    check({tag, "_brk0"}, brk_det0, 0);
    check({tag, "_data1"}, data1, 0);
    check({tag, "_ferr1"}, ferr1, 0);
    check({tag, "_perr1"}, perr1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, st, last0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(4);

    frame_check("a5", 0, 8'hA5, 0, 1);
    frame_check("par_bad", 1, 8'h3C, 1, 3);
    frame_check("par_ok", 1, 8'h3C, 0, 3);
    frame_check("stop2_bad", 1, 8'h55, good_pbit(8'h55, 1), 2'b01);
    frame_check("clean_2a", 1, 8'h2A, good_pbit(8'h2A, 1), 3);

    last0 = 8'hA5;
    for (int i = 0; i < 30; i++) begin
      d = i % 2;
      p = good_pbit(0, 0);
      if (d == 0) begin
        p  = $urandom_range(0, 255);
        st = ($urandom_range(0, 3) == 0) ? 0 : 1;
        frame_check("rnd0", 0, p, 0, st);
        last0 = p;
      end else begin
        p  = $urandom_range(0, 127);
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 3;
        frame_check("rnd1", 1, p, good_pbit(p, 1) ^ ($urandom_range(0, 3) == 0 ? 1 : 0), st);
      end
    end

    // Short low pulses must be rejected as glitches
    rx0 = 1'b0; wait_ticks(4); rx0 = 1'b1;
    rx1 = 1'b0; wait_ticks(2); rx1 = 1'b1;
    wait_ticks(32);
    check("glitch_q0", q0.size(), 0);
    check("glitch_q1", q1.size(), 0);
    check("glitch_hold0", data0, last0);

    frame_check("c3_ferr", 0, 8'hC3, 0, 0);

    // Reset after three data bits of 0xFF
    rx0 = 1'b0; wait_ticks(16);
    rx0 = 1'b1; wait_ticks(2 * 16 + 8 + 2);
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(32);
    check("midreset_q0", q0.size(), 0);
    check("midreset_q1", q1.size(), 0);
    frame_check("after_rst", 0, 8'h81, 0, 1);

    // Line break: 20 bit periods low
    brk0 = 0;
    rx0 = 1'b0; wait_ticks(20 * 16);
    if (BRK_EN) begin
      expect_entry("brk", 0, 0, 0, 1, 1);
      check("brk_pulses", brk0, 1);
      rx0 = 1'b1; wait_ticks(12 * 16);
      check("brk_after_rise", q0.size(), 0);
    end else begin
      rx0 = 1'b1; wait_ticks(12 * 16);
      check("brk_frames", q0.size() >= 2, 1);
      for (int i = 0; i < 2 && i < q0.size(); i++) begin
        check("brk_rep_data", q0[i][8:0], 0);
        check("brk_rep_ferr", q0[i][10], 1);
        check("brk_rep_flag", q0[i][11], 0);
      end
      check("brk_pulses", brk0, 0);
      q0.delete();
    end
    frame_check("post_brk", 0, 8'h33, 0, 1);
    check("brk1_pulses", brk1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver, successor to the fixed 8N1 receiver in the UART subsystem. Oversamples `rx` using the shared baud tick generator's `s_tick`. Supports:
- configurable data width, oversampling ratio, parity and stop-bit count;
- a two-flop input synchroniser;
- per-frame parity and framing error flags;
- optional line-break detection.

It feeds the RX FIFO and status registers of the UART top level.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period, even, legal 4..32.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `s_tick`, in, 1: oversampling tick, one-`clk` pulse; may be held high continuously.
- `rx`, in, 1: serial line, asynchronous, idle high.
- `rx_data`, out, `DATA_BITS`: last received word, LSB = first bit on the line.
- `rx_done_tick`, out, 1: one-`clk` pulse, frame complete.
- `parity_err`, out, 1: parity check failed on last frame; 0 when `PARITY_MODE`=0.
- `frame_err`, out, 1: any stop bit of last frame sampled 0.
- `break_det`, out, 1: one-`clk` pulse, line break detected.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). All FSM decisions use the synchronised `rxs`.
- Counters:
  - `sample_cnt` is `$clog2(OVERSAMPLE)` bits and increments only on `s_tick`.
  - `bit_cnt` is `$clog2(DATA_BITS+1)` bits.
  - The stop counter is 1 bit.
- FSM states and transitions:
  - **IDLE**: evaluated every `clk`, regardless of `s_tick`. On `rxs`=0, clear `sample_cnt` and go to START.
  - **START**: on the `s_tick` where `sample_cnt`=`OVERSAMPLE/2-1`, sample `rxs`. If 0: clear counters, go to DATA. If 1: glitch, go to IDLE, no output activity.
  - **DATA**: on the `s_tick` where `sample_cnt`=`OVERSAMPLE-1`, shift `rxs` into the MSB of the shift register (right shift, so LSB-first order) and increment `bit_cnt`. After the `DATA_BITS`-th bit, go to PARITY if `PARITY_MODE`≠0, else STOP.
  - **PARITY**: on `sample_cnt`=`OVERSAMPLE-1`, sample the parity bit.
    - Even mode: error when XOR of data and parity bit = 1.
    - Odd mode: error when that XOR = 0.
    - Go to STOP.
  - **STOP**: on `sample_cnt`=`OVERSAMPLE-1`, sample a stop bit and accumulate the framing error if it is 0. After `STOP_BITS` stop bits, complete the frame:
    - `rx_data` ← shift register;
    - `parity_err` and `frame_err` take the frame's values;
    - `rx_done_tick` = 1;
    - go to IDLE, or to BRK_WAIT (see Configuration).
- Errored frames are still delivered: `rx_done_tick` pulses and `rx_data` updates.
- `rx_data`, `parity_err` and `frame_err` hold until the next frame completes.
- Reset mid-frame clears everything immediately:
  - FSM to IDLE, counters to 0;
  - partial frame discarded;
  - no `rx_done_tick`.

## Timing
- Reset values: `rx_data`=0, `rx_done_tick`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, synchroniser=1.
- Input latency: 2 `clk` from `rx` to `rxs`.
- Sample points: mid-bit. The start bit is checked `OVERSAMPLE/2` ticks after the falling edge. Each later bit is sampled `OVERSAMPLE` ticks after the previous one.
- All outputs are registered. `rx_done_tick`, updated `rx_data` and the error flags appear in the `clk` cycle after the `s_tick` edge that samples the last stop bit.
- `rx_done_tick` is high for exactly 1 `clk`.
- A new start bit is accepted from the first IDLE cycle after `rx_done_tick`. There is no dead time beyond 1 `clk`.
- `s_tick` arriving while in IDLE is ignored.

## Configuration
- Macro `UART_RX_BREAK_DET_EN`.
- Defined:
  - A completed frame with data=0, parity bit 0 (if present) and all stop bits 0 asserts `break_det` for 1 `clk`, in the same cycle as `rx_done_tick`, with `frame_err`=1.
  - The FSM then enters BRK_WAIT and stays there until `rxs`=1, after which it returns to IDLE. The held-low line does not start further frames.
- Undefined:
  - `break_det` is tied 0 and there is no BRK_WAIT state.
  - A break is reported as a frame with `rx_data`=0 and `frame_err`=1. The FSM returns to IDLE and restarts frames while the line stays low.

## Test plan
1. Defaults (8N1, `OVERSAMPLE`=16), send 0xA5 → `rx_data`=0xA5, one-cycle `rx_done_tick`, `parity_err`=0, `frame_err`=0.
2. `PARITY_MODE`=1, send 0x3C with parity bit 1, then 0x3C with parity bit 0 → first frame `parity_err`=1 with `rx_data`=0x3C; second frame `parity_err`=0.
3. `STOP_BITS`=2, `DATA_BITS`=7, send 0x55 with the second stop bit 0 → `rx_data`=0x55, `frame_err`=1; next frame 0x2A is clean with `frame_err`=0.
4. Glitch and reset:
   - `rx` low for 4 ticks, then high → no `rx_done_tick`, FSM back in IDLE.
   - Assert `reset` after 3 data bits of 0xFF → all outputs 0, no done pulse.
   - The following frame 0x81 is received correctly.
5. Break: hold `rx` low for 20 bit periods.
   - With `UART_RX_BREAK_DET_EN`: exactly one `break_det` pulse and one `rx_done_tick` (`rx_data`=0x00, `frame_err`=1); no further done pulses until `rx` rises; then 0x33 is received cleanly.
   - Without the macro: repeated done pulses with `rx_data`=0x00 and `frame_err`=1; `break_det` stays 0.
